// File: rtl/rf_fwd_stage_pkg.sv
// rf_fwd_stage_pkg: shared widths, forwarding source type and operand priority resolve
package rf_fwd_stage_pkg;
  localparam int REG_W = 128;
  localparam int NUM_REGS = 128;
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int OP_W = 11;
  localparam int IMM_W = 18;
  localparam logic [0:OP_W-1] OP_NOP = '0;
  typedef struct packed {
    logic [0:REG_W-1] data;
    logic [0:ADDR_W-1] addr;
    logic we;
  } fwd_src_t;
  // Youngest producer wins: s2 > s3 > writeback > register table
  function automatic logic [0:REG_W-1] resolve_operand(
    input logic [0:ADDR_W-1] addr,
    input fwd_src_t s2,
    input fwd_src_t s3,
    input fwd_src_t wb,
    input logic [0:REG_W-1] rf_val
  );
    return (s2.we && s2.addr == addr) ? s2.data :
           (s3.we && s3.addr == addr) ? s3.data :
           (wb.we && wb.addr == addr) ? wb.data : rf_val;
  endfunction
endpackage

// File: rtl/rf_fwd_stage_if.sv
// rf_fwd_stage_if: decode fields, forwarding/writeback sources and the operand bundle to SimpleFixed2
interface rf_fwd_stage_if;
  import rf_fwd_stage_pkg::*;
  logic [0:OP_W-1] op_in, op;
  logic [2:0] format_in, format;
  logic [0:ADDR_W-1] rt_addr_in, ra_addr_in, rb_addr_in, rt_addr;
  logic [0:IMM_W-1] imm_in, imm;
  logic reg_write_in, reg_write;
  logic stall, flush;
  logic [0:REG_W-1] fwd_s2_data, fwd_s3_data, rt_wb;
  logic [0:ADDR_W-1] fwd_s2_addr, fwd_s3_addr, rt_addr_wb;
  logic fwd_s2_we, fwd_s3_we, reg_write_wb;
  logic [0:REG_W-1] ra, rb;
  modport master(
    output op_in, format_in, rt_addr_in, ra_addr_in, rb_addr_in, imm_in, reg_write_in,
    output stall, flush,
    output fwd_s2_data, fwd_s2_addr, fwd_s2_we, fwd_s3_data, fwd_s3_addr, fwd_s3_we,
    output rt_wb, rt_addr_wb, reg_write_wb,
    input op, format, rt_addr, imm, reg_write, ra, rb
  );
  modport slave(
    input op_in, format_in, rt_addr_in, ra_addr_in, rb_addr_in, imm_in, reg_write_in,
    input stall, flush,
    input fwd_s2_data, fwd_s2_addr, fwd_s2_we, fwd_s3_data, fwd_s3_addr, fwd_s3_we,
    input rt_wb, rt_addr_wb, reg_write_wb,
    output op, format, rt_addr, imm, reg_write, ra, rb
  );
endinterface

// File: rtl/rf_fwd_stage_reg_table.sv
// rf_fwd_stage_reg_table: NUM_REGS x REG_W register table, 2 async read / 1 write, write-through
module rf_fwd_stage_reg_table
  import rf_fwd_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic [0:ADDR_W-1] wa,
  input  logic [0:REG_W-1] wd,
  input  logic [0:ADDR_W-1] ra0,
  input  logic [0:ADDR_W-1] ra1,
  output logic [0:REG_W-1] rd0,
  output logic [0:REG_W-1] rd1
);
  logic [0:REG_W-1] mem [NUM_REGS];
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else if (we) mem[wa] <= wd;
  assign rd0 = (we && wa == ra0) ? wd : mem[ra0];
  assign rd1 = (we && wa == ra1) ? wd : mem[ra1];
endmodule

// File: rtl/rf_fwd_stage.sv
// rf_fwd_stage: register fetch with s2/s3/WB forwarding, registered operand bundle for SimpleFixed2
module rf_fwd_stage
  import rf_fwd_stage_pkg::*;
(
  input logic clk,
  input logic reset,
  rf_fwd_stage_if.slave bus
);
  logic [0:OP_W-1] op_q;
  logic [2:0] fmt_q;
  logic [0:ADDR_W-1] rt_q, ra_a, rb_a, ra_sel, rb_sel;
  logic [0:IMM_W-1] imm_q;
  logic rw_q;
  logic [0:REG_W-1] ra_q, rb_q, ra_rf, rb_rf, ra_res, rb_res;
  fwd_src_t s2, s3, wb;
  assign s2 = {bus.fwd_s2_data, bus.fwd_s2_addr, bus.fwd_s2_we};
  assign s3 = {bus.fwd_s3_data, bus.fwd_s3_addr, bus.fwd_s3_we};
  assign wb = {bus.rt_wb, bus.rt_addr_wb, bus.reg_write_wb};
  // While stalled the held instruction's sources keep being re-resolved
  assign ra_sel = bus.stall ? ra_a : bus.ra_addr_in;
  assign rb_sel = bus.stall ? rb_a : bus.rb_addr_in;
  rf_fwd_stage_reg_table u_table (
    .clk(clk), .reset(reset),
    .we(bus.reg_write_wb), .wa(bus.rt_addr_wb), .wd(bus.rt_wb),
    .ra0(ra_sel), .ra1(rb_sel), .rd0(ra_rf), .rd1(rb_rf)
  );
  assign ra_res = resolve_operand(ra_sel, s2, s3, wb, ra_rf);
  assign rb_res = resolve_operand(rb_sel, s2, s3, wb, rb_rf);
  always_ff @(posedge clk)
    if (reset || bus.flush) begin
      op_q <= OP_NOP;
      fmt_q <= '0;
      rt_q <= '0;
      imm_q <= '0;
      rw_q <= 1'b0;
      ra_q <= '0;
      rb_q <= '0;
      ra_a <= '0;
      rb_a <= '0;
    end else if (bus.stall) begin
      ra_q <= ra_res;
      rb_q <= rb_res;
    end else begin
      op_q <= bus.op_in;
      fmt_q <= bus.format_in;
      rt_q <= bus.rt_addr_in;
      imm_q <= bus.imm_in;
      rw_q <= bus.reg_write_in;
      ra_q <= ra_res;
      rb_q <= rb_res;
      ra_a <= bus.ra_addr_in;
      rb_a <= bus.rb_addr_in;
    end
  assign bus.op = op_q;
  assign bus.format = fmt_q;
  assign bus.rt_addr = rt_q;
  assign bus.imm = imm_q;
  assign bus.reg_write = rw_q;
  assign bus.ra = ra_q;
  assign bus.rb = rb_q;
endmodule

// File: tb/tb_rf_fwd_stage.sv
// tb_rf_fwd_stage: directed + random stimulus against an array-based register file model
module tb_rf_fwd_stage;
  import rf_fwd_stage_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  rf_fwd_stage_if b();
  rf_fwd_stage dut (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;
  localparam logic [0:OP_W-1] SHLH = 11'b00001011111;
  logic [0:REG_W-1] mrf [NUM_REGS];
  logic [0:OP_W-1] e_op;
  logic [2:0] e_fmt;
  logic [0:ADDR_W-1] e_rt, h_ra, h_rb;
  logic [0:IMM_W-1] e_imm;
  logic e_rw;
  logic [0:REG_W-1] e_ra, e_rb, saved;
  function automatic logic [0:REG_W-1] look(input logic [0:ADDR_W-1] a);
    if (b.fwd_s2_we && b.fwd_s2_addr == a) return b.fwd_s2_data;
    if (b.fwd_s3_we && b.fwd_s3_addr == a) return b.fwd_s3_data;
    if (b.reg_write_wb && b.rt_addr_wb == a) return b.rt_wb;
    return mrf[a];
  endfunction
  function automatic logic [0:REG_W-1] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic chk(input string tag, input logic [REG_W-1:0] obs, input logic [REG_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clr_exp();
    e_op = '0; e_fmt = '0; e_rt = '0; e_imm = '0; e_rw = 1'b0;
    e_ra = '0; e_rb = '0; h_ra = '0; h_rb = '0;
  endtask
  task automatic idle();
    b.op_in = '0; b.format_in = '0; b.rt_addr_in = '0; b.ra_addr_in = '0; b.rb_addr_in = '0;
    b.imm_in = '0; b.reg_write_in = 1'b0; b.stall = 1'b0; b.flush = 1'b0;
    b.fwd_s2_data = '0; b.fwd_s2_addr = '0; b.fwd_s2_we = 1'b0;
    b.fwd_s3_data = '0; b.fwd_s3_addr = '0; b.fwd_s3_we = 1'b0;
    b.rt_wb = '0; b.rt_addr_wb = '0; b.reg_write_wb = 1'b0;
  endtask
  task automatic step();
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mrf[i] = '0;
      clr_exp();
    end else begin
      if (b.flush) clr_exp();
      else if (b.stall) begin
        e_ra = look(h_ra);
        e_rb = look(h_rb);
      end else begin
        e_op = b.op_in; e_fmt = b.format_in; e_rt = b.rt_addr_in; e_imm = b.imm_in; e_rw = b.reg_write_in;
        e_ra = look(b.ra_addr_in); e_rb = look(b.rb_addr_in);
        h_ra = b.ra_addr_in; h_rb = b.rb_addr_in;
      end
      if (b.reg_write_wb) mrf[b.rt_addr_wb] = b.rt_wb;
    end
    @(posedge clk);
    #1;
    chk("op", b.op, e_op);
    chk("format", b.format, e_fmt);
    chk("rt_addr", b.rt_addr, e_rt);
    chk("imm", b.imm, e_imm);
    chk("reg_write", b.reg_write, e_rw);
    chk("ra", b.ra, e_ra);
    chk("rb", b.rb, e_rb);
  endtask
  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      b.ra_addr_in = ADDR_W'(i);
      step();
      chk("reset_read", b.ra, '0);
    end
    // WB then read, then same-cycle write-through
    idle();
    b.reg_write_wb = 1'b1; b.rt_addr_wb = 7'd3; b.rt_wb = {8{16'h0001}};
    step();
    idle();
    b.ra_addr_in = 7'd3;
    step();
    chk("wb_then_read", b.ra, {8{16'h0001}});
    b.reg_write_wb = 1'b1; b.rt_addr_wb = 7'd3; b.rt_wb = {8{16'hFFFF}};
    step();
    chk("write_through", b.ra, {8{16'hFFFF}});
    // Forwarding priority on r5
    idle();
    b.reg_write_wb = 1'b1; b.rt_addr_wb = 7'd5; b.rt_wb = {16{8'h11}};
    step();
    b.rt_wb = {16{8'h22}};
    b.fwd_s3_we = 1'b1; b.fwd_s3_addr = 7'd5; b.fwd_s3_data = {16{8'h33}};
    b.fwd_s2_we = 1'b1; b.fwd_s2_addr = 7'd5; b.fwd_s2_data = {16{8'h44}};
    b.ra_addr_in = 7'd5; b.rb_addr_in = 7'd5;
    step();
    chk("prio_s2_ra", b.ra, {16{8'h44}});
    chk("prio_s2_rb", b.rb, {16{8'h44}});
    b.fwd_s2_we = 1'b0;
    step();
    chk("prio_s3", b.ra, {16{8'h33}});
    b.fwd_s3_we = 1'b0;
    step();
    chk("prio_wb", b.rb, {16{8'h22}});
    // Stall re-resolve of a held shlh
    idle();
    b.op_in = SHLH; b.rt_addr_in = 7'd3; b.ra_addr_in = 7'd7; b.reg_write_in = 1'b1;
    step();
    b.stall = 1'b1;
    b.op_in = OP_W'($urandom()); b.rt_addr_in = 7'd100; b.ra_addr_in = 7'd1;
    step();
    b.fwd_s3_we = 1'b1; b.fwd_s3_addr = 7'd7; b.fwd_s3_data = {8{16'h0010}};
    step();
    chk("stall_op", b.op, SHLH);
    chk("stall_rt", b.rt_addr, 7'd3);
    chk("stall_fwd", b.ra, {8{16'h0010}});
    b.fwd_s3_we = 1'b0;
    b.reg_write_wb = 1'b1; b.rt_addr_wb = 7'd7; b.rt_wb = {8{16'h0010}};
    step();
    chk("stall_wb", b.ra, {8{16'h0010}});
    // Flush beats stall; WB still lands
    b.flush = 1'b1;
    saved = rnd128();
    b.rt_addr_wb = 7'd9; b.rt_wb = saved;
    step();
    chk("flush_op", b.op, '0);
    chk("flush_rw", b.reg_write, 1'b0);
    idle();
    b.ra_addr_in = 7'd9;
    step();
    chk("flush_wb", b.ra, saved);
    // Reset mid-stream with stall toggling
    idle();
    b.op_in = SHLH; b.rt_addr_in = 7'd3; b.ra_addr_in = 7'd3; b.reg_write_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b.stall = i[0];
      step();
    end
    reset = 1'b1;
    step();
    chk("rst_op", b.op, '0);
    chk("rst_ra", b.ra, '0);
    reset = 1'b0;
    idle();
    b.ra_addr_in = 7'd3;
    step();
    chk("rst_r3", b.ra, '0);
    // Randomized traffic over a narrow address window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      b.op_in = OP_W'($urandom());
      b.format_in = 3'($urandom());
      b.rt_addr_in = 7'($urandom_range(0, 7));
      b.ra_addr_in = 7'($urandom_range(0, 7));
      b.rb_addr_in = 7'($urandom_range(0, 7));
      b.imm_in = IMM_W'($urandom());
      b.reg_write_in = 1'($urandom());
      b.stall = ($urandom_range(0, 3) == 0);
      b.flush = ($urandom_range(0, 9) == 0);
      b.fwd_s2_we = 1'($urandom()); b.fwd_s2_addr = 7'($urandom_range(0, 7)); b.fwd_s2_data = rnd128();
      b.fwd_s3_we = 1'($urandom()); b.fwd_s3_addr = 7'($urandom_range(0, 7)); b.fwd_s3_data = rnd128();
      b.reg_write_wb = 1'($urandom()); b.rt_addr_wb = 7'($urandom_range(0, 7)); b.rt_wb = rnd128();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
